// File: rtl/seg_value_sequencer.sv
// seg_value_sequencer: buffers 32-bit words in a small FIFO and presents each one
// as eight hex digits for a fixed dwell time. The last word stays up while idle.
module seg_value_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_data_i,
    output logic [7:0][3:0]          value_o,
    output logic                     shown_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    // A one-cycle dwell still needs a one-bit counter that simply stays at zero.
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StShow, StExpired} state_e;

    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [31:0]     cur_q, cur_d;
    logic            shown_q, shown_d;
    state_e          state_q, state_d;

    logic full;
    logic push;
    logic pop;

    assign full       = (count_q == CntW'(DEPTH));
    // A pop in this cycle does not free a slot until the next cycle.
    assign in_ready_o = !full && !clear_i;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (count_q != '0) &&
                        ((state_q == StIdle) || (state_q == StExpired) ||
                         ((state_q == StShow) && (hold_q == '0)));

    assign value_o = cur_q;
    assign shown_o = shown_q;
    assign count_o = count_q;

    // Next-state for pointers, occupancy, dwell counter and display register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        cur_d    = cur_q;
        shown_d  = shown_q;
        state_d  = state_q;

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hold_d   = '0;
            cur_d    = '0;
            shown_d  = 1'b0;
            state_d  = StIdle;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                cur_d    = mem_q[rd_ptr_q];
                hold_d   = HoldW'(HOLD_CYCLES - 1);
                shown_d  = 1'b1;
                state_d  = StShow;
            end else begin
                case (state_q)
                    StShow: begin
                        if (hold_q != '0) begin
                            hold_d = hold_q - HoldW'(1);
                        end else begin
                            state_d = StExpired;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Control and display state; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            cur_q    <= '0;
            shown_q  <= 1'b0;
            state_q  <= StIdle;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            cur_q    <= cur_d;
            shown_q  <= shown_d;
            state_q  <= state_d;
        end
    end

    // FIFO storage; contents are don't-care after reset or clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_seg_value_sequencer.sv
// Directed bench for seg_value_sequencer with DEPTH=4, HOLD_CYCLES=4.
module tb_seg_value_sequencer;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            clear    = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     in_data  = '0;
    logic            in_ready;
    logic [7:0][3:0] value;
    logic            shown;
    logic [2:0]      count;

    int n_assert = 0;
    int n_fail   = 0;

    seg_value_sequencer #(
        .DEPTH       (4),
        .HOLD_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .value_o    (value),
        .shown_o    (shown),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word must be on the display now and for the following three cycles.
    task automatic check_hold(input string tag, input logic [31:0] word);
        chk({tag, "_c0"}, value, word);
        chk({tag, "_shown"}, {31'd0, shown}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("%s_c%0d", tag, i), value, word);
        end
    endtask

    logic [31:0] seen [$];
    int          stamp [$];
    logic [31:0] last;
    logic        acc;
    int          cyc;
    int          idx;

    initial begin
        // Reset values
        #1;
        chk("rst_in_ready_during", {31'd0, in_ready}, 32'd1);
        chk("rst_value_during", value, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        #2;
        chk("rst_value", value, 32'd0);
        chk("rst_shown", {31'd0, shown}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word: accepted at edge k, shown after edge k+1
        tick();
        in_valid = 1'b1;
        in_data  = 32'h1234_ABCD;
        tick();
        in_valid = 1'b0;
        chk("single_count_k", {29'd0, count}, 32'd1);
        chk("single_value_k", value, 32'd0);
        chk("single_shown_k", {31'd0, shown}, 32'd0);
        tick();
        chk("single_value_k1", value, 32'h1234_ABCD);
        chk("single_shown_k1", {31'd0, shown}, 32'd1);
        chk("single_count_k1", {29'd0, count}, 32'd0);
        repeat (12) tick();
        chk("single_value_expired", value, 32'h1234_ABCD);
        chk("single_shown_expired", {31'd0, shown}, 32'd1);

        // Backlog and full
        in_valid = 1'b1;
        in_data  = 32'h1111_1111;
        tick();
        in_data  = 32'h2222_2222;
        tick();
        chk("bl_first_pop", value, 32'h1111_1111);
        in_data  = 32'h3333_3333;
        tick();
        in_data  = 32'h4444_4444;
        tick();
        in_data  = 32'h5555_5555;
        chk("bl_ready_fifth", {31'd0, in_ready}, 32'd1);
        tick();
        in_data  = 32'h6666_6666;
        chk("bl_full_count", {29'd0, count}, 32'd4);
        chk("bl_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bl_first_held", value, 32'h1111_1111);
        tick();
        in_valid = 1'b0;
        chk("bl_count_after_pop", {29'd0, count}, 32'd3);
        check_hold("bl_w2", 32'h2222_2222);
        tick();
        check_hold("bl_w3", 32'h3333_3333);
        tick();
        check_hold("bl_w4", 32'h4444_4444);
        tick();
        check_hold("bl_w5", 32'h5555_5555);
        repeat (6) tick();
        chk("bl_no_sixth", value, 32'h5555_5555);
        chk("bl_drained", {29'd0, count}, 32'd0);

        // Wrap-around: ten words streamed with in_valid held high
        last     = value;
        cyc      = 0;
        idx      = 0;
        in_valid = 1'b1;
        in_data  = 32'hA000_0000;
        while (seen.size() < 10 && cyc < 200) begin
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 10) in_valid = 1'b0;
                else in_data = 32'hA000_0000 + idx;
            end
            if (value !== last) begin
                seen.push_back(value);
                stamp.push_back(cyc);
                last = value;
            end
        end
        in_valid = 1'b0;
        chk("wrap_num_words", seen.size(), 32'd10);
        for (int i = 0; i < seen.size() && i < 10; i++) begin
            chk($sformatf("wrap_word%0d", i), seen[i], 32'hA000_0000 + i);
        end
        for (int i = 0; i + 1 < stamp.size() && i < 9; i++) begin
            chk($sformatf("wrap_dwell%0d", i), stamp[i+1] - stamp[i], 32'd4);
        end
        repeat (6) tick();
        chk("wrap_last_kept", value, 32'hA000_0009);
        chk("wrap_count_end", {29'd0, count}, 32'd0);

        // Clear race: count=3 mid-dwell, clear together with a push
        in_valid = 1'b1;
        in_data  = 32'hB000_0001;
        tick();
        in_data  = 32'hB000_0002;
        tick();
        in_data  = 32'hB000_0003;
        tick();
        in_data  = 32'hB000_0004;
        tick();
        chk("clr_pre_count", {29'd0, count}, 32'd3);
        chk("clr_pre_value", value, 32'hB000_0001);
        clear   = 1'b1;
        in_data = 32'hDEAD_BEEF;
        #1;
        chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", {29'd0, count}, 32'd0);
        chk("clr_value", value, 32'd0);
        chk("clr_shown", {31'd0, shown}, 32'd0);
        repeat (8) tick();
        chk("clr_stays_blank", value, 32'd0);
        chk("clr_stays_unshown", {31'd0, shown}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hC000_00C0;
        tick();
        in_valid = 1'b0;
        chk("clr_push_k", value, 32'd0);
        tick();
        chk("clr_push_k1", value, 32'hC000_00C0);
        chk("clr_push_shown", {31'd0, shown}, 32'd1);

        // Async reset mid-dwell
        in_valid = 1'b1;
        in_data  = 32'hD000_00D1;
        tick();
        in_data  = 32'hD000_00D2;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_count", {29'd0, count}, 32'd2);
        chk("ar_pre_value", value, 32'hC000_00C0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_value_async", value, 32'd0);
        chk("ar_shown_async", {31'd0, shown}, 32'd0);
        chk("ar_count_async", {29'd0, count}, 32'd0);
        chk("ar_ready_async", {31'd0, in_ready}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("ar_old_never_shown", value, 32'd0);
        chk("ar_shown_after", {31'd0, shown}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hE000_00E0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ar_new_word", value, 32'hE000_00E0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
